bootrom_copier: RTL and testbench

Bus initiator that copies a block of 32-bit words from a source region (typically the boot ROM data port) to a destination region (typically RAM) over the word-addressed access/cs/ack data bus. Software or the reset sequencer programs source, destination and length, pulses `start`, and waits for `done`. One read and one write are issued per word, each held until acknowledged, with a bounded wait that aborts the copy on a missing ack.

---
 rtl/bootrom_copier.sv | 174 +++++++++++++++++
 tb/tb_bootrom_copier.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bootrom_copier.sv
// -----------------------------------------------------------------------------
// bootrom_copier
//
// Bus initiator that copies a block of 32-bit words from a source region to a
// destination region over a word-addressed access/cs/ack bus. Each word is one
// read followed by one write. Each request is held until it is acknowledged,
// and one idle turnaround cycle follows every acknowledged request. If a
// request waits too long without an acknowledge, the copy is aborted and
// flagged.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle copy request; ignored while a copy is running
//   src_addr/dst_addr first source / destination word addresses
//   word_count        number of words to copy (0 finishes at once)
//   busy, done, error copy status; done pulses once, error sticks until start
//   m_access, m_cs    bus request valid (identical signals)
//   m_addr, m_wr_en   word address and direction (1 = write)
//   m_bytesel         all lanes enabled while requesting
//   m_wr_val          write data
//   m_data, m_ack     responder read data and acknowledge
// -----------------------------------------------------------------------------
module bootrom_copier #(
  parameter int CNT_WIDTH = 12,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [29:0]          src_addr,
  input  logic [29:0]          dst_addr,
  input  logic [CNT_WIDTH-1:0] word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 m_access,
  output logic                 m_cs,
  output logic [29:0]          m_addr,
  output logic                 m_wr_en,
  output logic [3:0]           m_bytesel,
  output logic [31:0]          m_wr_val,
  input  logic [31:0]          m_data,
  input  logic                 m_ack
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, FIN} state_t;

  state_t               state_q, state_d;
  logic [29:0]          src_q, src_d;
  logic [29:0]          dst_q, dst_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [31:0]          data_q, data_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 error_d;
  logic                 timed_out;

  // Registered bus/status outputs, computed from the next state.
  logic                 busy_d, done_d, access_d, wr_en_d;
  logic [29:0]          addr_d;
  logic [31:0]          wr_val_d;

  assign timed_out = (wait_q == WAIT_W'(TIMEOUT));

  // Next-state logic.
  // NOTE: every variable gets a default before the case statement, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    error_d     = error;
    // The wait counter restarts at zero on every entry into RD or WR.
    wait_d      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d       = src_addr;
          dst_d       = dst_addr;
          remaining_d = word_count;
          error_d     = 1'b0;
          state_d     = (word_count == '0) ? FIN : RD;
        end
      end
      RD: begin
        // An ack arriving on the timeout cycle still completes the transfer.
        if (m_ack) begin
          data_d  = m_data;
          src_d   = src_q + 30'd1;
          state_d = RD_GAP;
        end else if (timed_out) begin
          error_d = 1'b1;
          state_d = FIN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RD_GAP: state_d = WR;
      WR: begin
        if (m_ack) begin
          dst_d = dst_q + 30'd1;
          if (remaining_q != '0) remaining_d = remaining_q - CNT_WIDTH'(1);
          state_d = WR_GAP;
        end else if (timed_out) begin
          error_d = 1'b1;
          state_d = FIN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WR_GAP:  state_d = (remaining_q == '0) ? FIN : RD;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, so every port comes from a flop.
  always_comb begin
    busy_d   = state_d inside {RD, RD_GAP, WR, WR_GAP};
    done_d   = (state_d == FIN);
    access_d = state_d inside {RD, WR};
    wr_en_d  = (state_d == WR);
    addr_d   = '0;
    wr_val_d = '0;
    if (state_d == RD) addr_d = src_d;
    if (state_d == WR) begin
      addr_d   = dst_d;
      wr_val_d = data_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      wait_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      m_access    <= 1'b0;
      m_cs        <= 1'b0;
      m_wr_en     <= 1'b0;
      m_bytesel   <= 4'b0000;
      m_addr      <= '0;
      m_wr_val    <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      wait_q      <= wait_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      m_access    <= access_d;
      m_cs        <= access_d;
      m_wr_en     <= wr_en_d;
      m_bytesel   <= access_d ? 4'b1111 : 4'b0000;
      m_addr      <= addr_d;
      m_wr_val    <= wr_val_d;
    end
  end

endmodule

// File: tb/tb_bootrom_copier.sv
// -----------------------------------------------------------------------------
// tb_bootrom_copier
//
// Self-checking bench for bootrom_copier (TIMEOUT = 8). A negedge-driven
// responder acks each request after a programmable number of wait cycles
// (zero-wait = ack registered one cycle after the request), returns ROM
// contents on reads and logs every completed transfer. A table of copy jobs
// with hand-computed latencies drives the main checks; hand-written sequences
// cover reset, stray acks/starts and reset in the middle of a copy.
// -----------------------------------------------------------------------------
module tb_bootrom_copier;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [29:0] src_addr, dst_addr;
  logic [11:0] word_count;
  logic        busy, done, error;
  logic        m_access, m_cs, m_wr_en, m_ack;
  logic [29:0] m_addr;
  logic [3:0]  m_bytesel;
  logic [31:0] m_wr_val, m_data;

  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] rd_data = 32'hdead0000;
  int          wait_n = 0;
  int          stall_idx = -1;
  int          held = 0;
  int          last_held = 0;
  int          proto_bad = 0;
  logic [29:0] rd_log[$];
  logic [29:0] wr_log_addr[$];
  logic [31:0] wr_log_data[$];

  int n_cmp = 0;
  int n_bad = 0;

  assign m_ack  = resp_ack | stray_ack;
  assign m_data = rd_data;

  bootrom_copier #(.CNT_WIDTH(12), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
    .busy(busy), .done(done), .error(error),
    .m_access(m_access), .m_cs(m_cs), .m_addr(m_addr), .m_wr_en(m_wr_en),
    .m_bytesel(m_bytesel), .m_wr_val(m_wr_val), .m_data(m_data), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    if (a < 30'd4) return 32'h11111111 * (32'(a) + 32'd1);
    return {2'b11, a};
  endfunction

  // Responder: one request is acked once it has been held wait_n+1 cycles,
  // except the write whose log index equals stall_idx, which is never acked.
  always @(negedge clk) begin
    if (m_access) begin
      if (m_cs !== 1'b1 || m_bytesel !== 4'hf) proto_bad++;
      if (resp_ack) begin
        resp_ack = 1'b0;
        rd_data  = 32'hdead0000;
      end else if (held >= wait_n + 1 &&
                   !(m_wr_en && wr_log_addr.size() == stall_idx)) begin
        resp_ack = 1'b1;
        if (m_wr_en) begin
          wr_log_addr.push_back(m_addr);
          wr_log_data.push_back(m_wr_val);
        end else begin
          rd_log.push_back(m_addr);
          rd_data = rom_word(m_addr);
        end
      end
      held++;
    end else begin
      if (m_cs !== 1'b0 || m_bytesel !== 4'h0) proto_bad++;
      if (held != 0) last_held = held;
      held     = 0;
      resp_ack = 1'b0;
      rd_data  = 32'hdead0000;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [29:0] src;
    logic [29:0] dst;
    logic [11:0] n;
    int          wait_n;
    bit          stall;       // withhold ack on the 2nd write
    int          exp_cycles;  // sampling edge of start -> done, inclusive
    bit          exp_err;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs[7];

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {m_access, m_cs, m_wr_en, m_bytesel, busy, done, error}, '0);
    check({tag, "_addr"}, m_addr, '0);
    check({tag, "_wrval"}, m_wr_val, '0);
  endtask

  task automatic do_vec(input vec_t v, input bit stray, input string tag);
    int rb, wb, pb, cycles;
    logic busy_first, acc_first, err_first, err_done, acc_done;
    logic [29:0] a;
    rb = rd_log.size();
    wb = wr_log_addr.size();
    pb = proto_bad;
    wait_n    = v.wait_n;
    stall_idx = v.stall ? wb + 1 : -1;
    src_addr = v.src; dst_addr = v.dst; word_count = v.n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    busy_first = busy; acc_first = m_access; err_first = error;
    while (!done && cycles < 300) begin
      if (stray) begin
        // Acks only while no request is up; starts with junk operands.
        stray_ack  = !m_access;
        start      = (cycles % 3 == 1);
        src_addr   = 30'h999;
        dst_addr   = 30'h777;
        word_count = 12'd7;
      end
      @(negedge clk);
      cycles++;
    end
    err_done = error; acc_done = m_access;
    if (stray) begin
      start     = 1'b1;   // sampled while in FIN: must be ignored
      stray_ack = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; stray_ack = 1'b0;
    check({tag, "_done_latency"}, cycles, v.exp_cycles);
    check({tag, "_busy_first"}, busy_first, v.n != 0);
    check({tag, "_access_first"}, acc_first, v.n != 0);
    check({tag, "_error_cleared"}, err_first, 1'b0);
    check({tag, "_error_at_done"}, err_done, v.exp_err);
    check({tag, "_access_at_done"}, acc_done, 1'b0);
    check({tag, "_post_state"}, {busy, done, m_access}, 3'b000);
    check({tag, "_error_held"}, error, v.exp_err);
    check({tag, "_reads"}, rd_log.size() - rb, v.exp_rd);
    check({tag, "_writes"}, wr_log_addr.size() - wb, v.exp_wr);
    check({tag, "_protocol"}, proto_bad - pb, 0);
    if (v.stall) check({tag, "_stall_len"}, last_held, TO + 1);
    for (int i = 0; i < v.exp_rd && rb + i < rd_log.size(); i++) begin
      a = v.src + 30'(i);
      check($sformatf("%s_rd%0d_addr", tag, i), rd_log[rb + i], a);
    end
    for (int i = 0; i < v.exp_wr && wb + i < wr_log_addr.size(); i++) begin
      a = v.dst + 30'(i);
      check($sformatf("%s_wr%0d_addr", tag, i), wr_log_addr[wb + i], a);
      a = v.src + 30'(i);
      check($sformatf("%s_wr%0d_data", tag, i), wr_log_data[wb + i], rom_word(a));
    end
  endtask

  initial begin
    vec_t sv;
    bit   found;
    //          src           dst           n      w  st cyc err rd wr
    vecs[0] = '{30'h0,        30'h400,      12'd4, 0, 0, 25, 0,  4, 4};
    vecs[1] = '{30'h55,       30'h123,      12'd0, 0, 0, 1,  0,  0, 0};
    vecs[2] = '{30'h3ffffffe, 30'h100,      12'd3, 0, 0, 19, 0,  3, 3};
    vecs[3] = '{30'h2,        30'h3ffffffe, 12'd1, 2, 0, 11, 0,  1, 1};
    vecs[4] = '{30'h10,       30'h3fffffff, 12'd2, 1, 0, 17, 0,  2, 2};
    vecs[5] = '{30'h0,        30'h400,      12'd4, 0, 1, 19, 1,  2, 1};
    vecs[6] = '{30'h1,        30'h200,      12'd1, 0, 0, 7,  0,  1, 1};

    rst = 1'b1; start = 1'b0;
    src_addr = '0; dst_addr = '0; word_count = '0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("idle_after_reset");

    // Stray acks while idle must not start anything.
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    check("idle_stray_ack", {busy, done, m_access}, 3'b000);

    for (int i = 0; i < 7; i++) do_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Stray acks in the gaps, junk starts mid-copy and in FIN.
    sv = '{30'h20, 30'h300, 12'd3, 0, 0, 19, 0, 3, 3};
    do_vec(sv, 1'b1, "stray");

    // Reset while the second write is on the bus.
    wait_n = 0; stall_idx = -1;
    src_addr = 30'h0; dst_addr = 30'h400; word_count = 12'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_access && m_wr_en && m_addr == 30'h401) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_wr2", found, 1'b1);
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid_copy");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_vec(vecs[0], 1'b0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
